// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared types and constants for the sequential RAM-backed divider.
//   state_t      - controller state encoding
//   DEF_DATA_W   - default operand/result width
//   DEF_ADDR_W   - default RAM address width (8 words)
//   DEF_*_ADDR   - fixed RAM word locations of dividend, divisor, quotient, remainder
//   DIV0_Q       - quotient reported for a zero divisor
package div_seq_pkg;

    localparam int DEF_DATA_W = 32'd16;
    localparam int DEF_ADDR_W = 32'd3;

    localparam int DEF_A_ADDR = 32'd0;
    localparam int DEF_B_ADDR = 32'd1;
    localparam int DEF_Q_ADDR = 32'd2;
    localparam int DEF_R_ADDR = 32'd3;

    localparam logic [DEF_DATA_W-1:0] DIV0_Q = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_CHECK = 3'd3,
        S_SUB   = 3'd4,
        S_WR_Q  = 3'd5,
        S_WR_R  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one-cycle divide datapath holding the running quotient and remainder.
// Build option: DIV_SEQ_FAST_EN selects a fixed-length restoring shift-subtract
// (DATA_W steps); otherwise one repeated subtraction is done per step.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   init        - load registers from dividend a (div0 selects the zero-divisor result)
//   div0        - divisor is zero (only meaningful with init)
//   step        - perform one iteration this cycle
//   a, b        - dividend, divisor (stable while stepping)
//   q_d, rem_d  - next-cycle quotient/remainder (what the registers take at this edge)
//   fin         - asserted in the last step cycle
module div_step
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              div0,
    input  logic              step,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] q_d,
    output logic [DATA_W-1:0] rem_d,
    output logic              fin
);

    logic [DATA_W-1:0] q_r;
    logic [DATA_W-1:0] rem_r;

`ifdef DIV_SEQ_FAST_EN
    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W:0]   trial_s;

    // Restoring shift-subtract: q_r starts as the dividend and is shifted out MSB first
    // while quotient bits are shifted in at the LSB.
    always_comb begin
        q_d     = q_r;
        rem_d   = rem_r;
        cnt_d   = cnt_r;
        fin     = 1'b0;
        trial_s = {rem_r, q_r[DATA_W-1]};
        if (init) begin
            cnt_d = {CNT_W{1'b0}};
            if (div0) begin
                q_d   = DATA_W'(DIV0_Q);
                rem_d = a;
            end else begin
                q_d   = a;
                rem_d = {DATA_W{1'b0}};
            end
        end else if (step) begin
            cnt_d = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            fin   = (cnt_r == CNT_W'(DATA_W - 1));
            if (trial_s >= {1'b0, b}) begin
                rem_d = DATA_W'(trial_s - {1'b0, b});
                q_d   = {q_r[DATA_W-2:0], 1'b1};
            end else begin
                rem_d = trial_s[DATA_W-1:0];
                q_d   = {q_r[DATA_W-2:0], 1'b0};
            end
        end else begin
            cnt_d = cnt_r;
        end
    end

    // Step counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_d;
        end
    end
`else
    // Repeated subtraction: one subtract per cycle while rem >= b; the first cycle
    // where it fails leaves the registers alone and flags completion.
    always_comb begin
        q_d   = q_r;
        rem_d = rem_r;
        fin   = 1'b0;
        if (init) begin
            rem_d = a;
            if (div0) begin
                q_d = DATA_W'(DIV0_Q);
            end else begin
                q_d = {DATA_W{1'b0}};
            end
        end else if (step) begin
            if (rem_r >= b) begin
                rem_d = rem_r - b;
                q_d   = q_r + {{(DATA_W-1){1'b0}}, 1'b1};
            end else begin
                fin = 1'b1;
            end
        end else begin
            fin = 1'b0;
        end
    end
`endif

    // Quotient / remainder registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= {DATA_W{1'b0}};
            rem_r <= {DATA_W{1'b0}};
        end else begin
            q_r   <= q_d;
            rem_r <= rem_d;
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencer that reads dividend/divisor from a shared 8x16 register-file
// RAM, divides them over several cycles and writes quotient/remainder back.
// Build option: DIV_SEQ_FAST_EN (fixed DATA_W-step shift-subtract in div_step).
// Ports:
//   CLK, RST            - clock (rising edge), synchronous active-high reset
//   start               - request, sampled only in IDLE
//   busy                - high from RD_A through DONE
//   done                - one-cycle pulse in DONE
//   err                 - divide-by-zero flag, held until the next accepted start
//   quotient, remainder - last results, held
//   ram_addr, ram_rd, ram_wr, ram_wdata - RAM request (one strobe at a time)
//   ram_rdata           - RAM read data, valid in the same cycle as the read request
module div_seq_ctrl
    import div_seq_pkg::*;
#(
    parameter int                 DATA_W = DEF_DATA_W,
    parameter int                 ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  A_ADDR = ADDR_W'(DEF_A_ADDR),
    parameter logic [ADDR_W-1:0]  B_ADDR = ADDR_W'(DEF_B_ADDR),
    parameter logic [ADDR_W-1:0]  Q_ADDR = ADDR_W'(DEF_Q_ADDR),
    parameter logic [ADDR_W-1:0]  R_ADDR = ADDR_W'(DEF_R_ADDR)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic              div0_s;
    logic              init_s;
    logic              step_s;
    logic              fin_s;
    logic [DATA_W-1:0] q_d_s;
    logic [DATA_W-1:0] rem_d_s;

    assign div0_s = (b_r == {DATA_W{1'b0}});

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .clk   (CLK),
        .rst   (RST),
        .init  (init_s),
        .div0  (div0_s),
        .step  (step_s),
        .a     (a_r),
        .b     (b_r),
        .q_d   (q_d_s),
        .rem_d (rem_d_s),
        .fin   (fin_s)
    );

    // Next-state and datapath control.
    always_comb begin
        state_s = state_r;
        init_s  = 1'b0;
        step_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_RD_A;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD_A:  state_s = S_RD_B;
            S_RD_B:  state_s = S_CHECK;
            S_CHECK: begin
                init_s = 1'b1;
                if (div0_s) begin
                    state_s = S_WR_Q;
                end else begin
                    state_s = S_SUB;
                end
            end
            S_SUB: begin
                step_s = 1'b1;
                if (fin_s) begin
                    state_s = S_WR_Q;
                end else begin
                    state_s = S_SUB;
                end
            end
            S_WR_Q:  state_s = S_WR_R;
            S_WR_R:  state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, operand capture and error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_IDLE;
            a_r     <= {DATA_W{1'b0}};
            b_r     <= {DATA_W{1'b0}};
            err     <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == S_RD_A) begin
                a_r <= ram_rdata;
            end
            if (state_r == S_RD_B) begin
                b_r <= ram_rdata;
            end
            if ((state_r == S_IDLE) && start) begin
                err <= 1'b0;
            end else if (state_r == S_CHECK) begin
                err <= div0_s;
            end
        end
    end

    // Registered outputs decoded from the state being entered, so they line up with it.
    // Write data uses the datapath's next values because the final step lands on the
    // same edge that enters WR_Q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= {ADDR_W{1'b0}};
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_wdata <= {DATA_W{1'b0}};
            quotient  <= {DATA_W{1'b0}};
            remainder <= {DATA_W{1'b0}};
        end else begin
            busy   <= (state_s != S_IDLE);
            done   <= (state_s == S_DONE);
            ram_rd <= 1'b0;
            ram_wr <= 1'b0;
            case (state_s)
                S_RD_A: begin
                    ram_addr <= A_ADDR;
                    ram_rd   <= 1'b1;
                end
                S_RD_B: begin
                    ram_addr <= B_ADDR;
                    ram_rd   <= 1'b1;
                end
                S_WR_Q: begin
                    ram_addr  <= Q_ADDR;
                    ram_wr    <= 1'b1;
                    ram_wdata <= q_d_s;
                end
                S_WR_R: begin
                    ram_addr  <= R_ADDR;
                    ram_wr    <= 1'b1;
                    ram_wdata <= rem_d_s;
                end
                S_DONE: begin
                    quotient  <= q_d_s;
                    remainder <= rem_d_s;
                end
                default: begin
                    ram_rd <= 1'b0;
                    ram_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed self-checking bench for div_seq_ctrl with a behavioural
// 8x16 RAM (combinational read, write at the rising edge).
module tb_div_seq_ctrl;

    localparam int LIMIT = 70000;
`ifdef DIV_SEQ_FAST_EN
    localparam int LAT_100_7 = 22;
    localparam int LAT_5_9   = 22;
    localparam int LAT_MAX_1 = 22;
`else
    localparam int LAT_100_7 = 21;
    localparam int LAT_5_9   = 7;
    localparam int LAT_MAX_1 = 65542;
`endif
    localparam int LAT_DIV0  = 6;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic [2:0]  ram_addr;
    logic        ram_rd;
    logic        ram_wr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] mem [0:7];
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = 3'd0;
    logic [15:0] ld_data = 16'd0;
    int          wr2 = 0;
    int          wr3 = 0;
    int          done_cnt = 0;
    int          conflicts = 0;

    int          checks = 0;
    int          errors = 0;

    div_seq_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .quotient  (quotient),
        .remainder (remainder),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_wr    (ram_wr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 CLK = ~CLK;

    assign ram_rdata = mem[ram_addr];

    always @(posedge CLK) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (ram_wr) begin
            mem[ram_addr] <= ram_wdata;
            if (ram_addr == 3'd2) wr2 <= wr2 + 1;
            if (ram_addr == 3'd3) wr3 <= wr3 + 1;
        end
        if (ram_rd && ram_wr) conflicts <= conflicts + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [2:0] addr, input logic [15:0] data);
        @(negedge CLK);
        ld_addr = addr;
        ld_data = data;
        ld_en   = 1'b1;
        @(negedge CLK);
        ld_en   = 1'b0;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic ee,
                       input int elat, input int extra, input string tag);
        int cyc;
        int w2;
        int w3;
        int d0;
        logic seen;
        logic gap;
        poke(3'd0, a);
        poke(3'd1, b);
        w2 = wr2;
        w3 = wr3;
        d0 = done_cnt;
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        gap  = 1'b0;
        while (cyc < LIMIT) begin
            @(negedge CLK);
            start = (cyc == extra);
            if (busy !== 1'b1) gap = 1'b1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge CLK);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(elat));
        check({tag, "_quotient"}, 32'(quotient), 32'(eq));
        check({tag, "_remainder"}, 32'(remainder), 32'(er));
        check({tag, "_err"}, 32'(err), 32'(ee));
        check({tag, "_ram_q"}, 32'(mem[2]), 32'(eq));
        check({tag, "_ram_r"}, 32'(mem[3]), 32'(er));
        check({tag, "_busy_continuous"}, 32'(gap), 32'd0);
        @(posedge CLK);
        #1;
        check({tag, "_done_after"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_writes_q"}, 32'(wr2 - w2), 32'd1);
        check({tag, "_writes_r"}, 32'(wr3 - w3), 32'd1);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int w2;
        int w3;
        RST   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_rd", 32'(ram_rd), 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        RST = 1'b0;

        // Start held in IDLE without a pulse yet: must remain idle while low.
        @(negedge CLK);
        check("idle_busy", 32'(busy), 32'd0);

        run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, LAT_100_7, 0, "d100_7");
        run(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, LAT_5_9, 0, "d5_9");
        run(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, LAT_DIV0, 0, "d1234_0");
        // Extra start pulse in cycle 6 (inside SUB) must be ignored; err clears on start.
        run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, LAT_100_7, 6, "restart_ign");

        // Reset in the 5th SUB cycle (cycle 8): no writes, outputs cleared.
        poke(3'd2, 16'hDEAD);
        poke(3'd3, 16'hBEEF);
        poke(3'd0, 16'd100);
        poke(3'd1, 16'd7);
        w2 = wr2;
        w3 = wr3;
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ram_wr", 32'(ram_wr), 32'd0);
        check("mid_rst_quotient", 32'(quotient), 32'd0);
        repeat (4) @(posedge CLK);
        #1;
        check("mid_rst_still_idle", 32'(busy), 32'd0);
        check("mid_rst_ram_q", 32'(mem[2]), 32'hDEAD);
        check("mid_rst_ram_r", 32'(mem[3]), 32'hBEEF);
        check("mid_rst_no_wr_q", 32'(wr2 - w2), 32'd0);
        check("mid_rst_no_wr_r", 32'(wr3 - w3), 32'd0);
        run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, LAT_100_7, 0, "after_rst");

        run(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, LAT_MAX_1, 0, "dmax_1");

        check("rd_wr_exclusive", 32'(conflicts), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
